data_bus_arbiter: RTL and testbench
===================================

// Module: data_bus_arbiter
// PURPOSE
//  Round-robin arbiter and sequencer for the shared 32-bit data bus linking the FFT, FIR and IIR units.
//  - Picks one source unit whose output FIFO has data.
//  - Pops a word from that source and drives it on data_bus.
//  - Pushes the word into the destination unit's input FIFO named by the source's route select.
//  - Sits between the unit FIFOs and the data bus controller mux.
// PARAMETERS
//  DATA_W     32  bus/data width
//  BURST_LEN  4   max words moved per grant before priority rotates (1..15)
// PORTS
//  clk          in   1       system clock, rising edge
//  rst_n        in   1       asynchronous active-low reset
//  enable       in   1       1 = new grants allowed
//  req          in   3       source has data (~empty of output FIFO); [0]=fft [1]=fir [2]=iir
//  dst_sel_fft  in   2       FFT route: 0=fft 1=fir 2=iir 3=reserved
//  dst_sel_fir  in   2       FIR route, same encoding
//  dst_sel_iir  in   2       IIR route, same encoding
//  dst_full     in   3       destination input FIFO full; bit order as req
//  fft_data_in  in   DATA_W  FFT output FIFO read data (valid cycle after pop)
//  fir_data_in  in   DATA_W  FIR output FIFO read data
//  iir_data_in  in   DATA_W  IIR output FIFO read data
//  src_pop      out  3       one-cycle pop strobe to source output FIFO
//  dst_push     out  3       one-cycle push strobe to destination input FIFO
//  grant        out  3       one-hot owner of bus; 0 when idle
//  data_bus     out  DATA_W  transferred word; 0 outside XFER
//  busy         out  1       1 in POP or XFER
//  route_err    out  1       registered; 1 while idle and a requester has illegal route
// BEHAVIOUR
//  Reset (async, rst_n=0)
//   - State=IDLE, grant=0, src_pop=0, dst_push=0, route_err=0, burst count=0.
//   - Round-robin pointer last=2 (iir), so fft has first priority.
//   - A word popped but not yet pushed is lost; this is accepted.
//  Eligibility of source i: req[i] & dst_sel_i!=3 & dst_sel_i!=i & ~dst_full[dst_sel_i].
//  route_err: set next cycle if state=IDLE and some req[i] has dst_sel_i==3 or ==i.
//   - Such a source is never granted.
//  FSM states: IDLE, POP, XFER.
//   IDLE
//    - If enable and any source eligible: grant the first eligible source searching last+1, last+2, last+3 (mod 3).
//    - Latch grant and destination; count=0; go to POP.
//   POP
//    - If req[g] & ~dst_full[d] & (count==0 | enable): src_pop[g]=1 for this cycle; go to XFER.
//    - Otherwise: release to IDLE, no pop, last=g.
//   XFER
//    - data_bus = granted source data; dst_push[d]=1; count=count+1.
//    - If count+1==BURST_LEN: go to IDLE, last=g.
//    - Otherwise: go to POP.
//  Latency: eligible in IDLE at cycle T -> pop at T+1 -> push and data at T+2.
//   - Throughput is 1 word per 2 cycles within a burst.
//  Full and empty are sampled in POP, one cycle after the previous push or pop.
//   - This holds because the FIFO flags are registered.
//   - Result: no overflow and no underflow.
//  At most one bit of src_pop, of dst_push and of grant is 1 in any cycle.
//  Route selects are latched at grant; changes mid-burst take effect at the next grant.
//  enable=0 mid-burst: the in-flight XFER completes, the next POP releases, and no new grants are made.
//  Simultaneous requests: resolved only by the round-robin order; no source waits more than 2 grants.
// TESTING
//  1. Async reset: rst_n=0 mid-XFER -> all outputs 0 at once; after release, fft and iir request -> fft granted first.
//  2. fft->fir, 3 words, BURST_LEN=4, IDLE at T -> pops at T+1/3/5, pushes at T+2/4/6, data_bus matches; POP at T+7 releases.
//  3. All three eligible, deep FIFOs -> grant order fft, fir, iir, fft; 4 words each; grant stays one-hot.
//  4. fir->iir with dst_full[2]=1, fft->fir eligible -> fft served, fir held; clear full -> fir granted next.
//  5. dst_sel_iir=2 or 3 with req[2]=1 -> route_err=1, no grant to iir; fix route -> route_err=0, iir served.
//  6. enable=0 during the second POP of an fft burst -> no pop, back to IDLE; enable=1 -> fir (next in order) granted.

Source files
------------

// File: rtl/data_bus_arbiter.sv
// Round-robin arbiter/sequencer moving words from the FFT/FIR/IIR output FIFOs
// over the shared data bus into the routed destination input FIFO.
module data_bus_arbiter #(
  parameter int DATA_W    = 32,
  parameter int BURST_LEN = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [2:0]        req,
  input  logic [1:0]        dst_sel_fft,
  input  logic [1:0]        dst_sel_fir,
  input  logic [1:0]        dst_sel_iir,
  input  logic [2:0]        dst_full,
  input  logic [DATA_W-1:0] fft_data_in,
  input  logic [DATA_W-1:0] fir_data_in,
  input  logic [DATA_W-1:0] iir_data_in,
  output logic [2:0]        src_pop,
  output logic [2:0]        dst_push,
  output logic [2:0]        grant,
  output logic [DATA_W-1:0] data_bus,
  output logic              busy,
  output logic              route_err
);

  typedef enum logic [1:0] {IDLE, POP, XFER} state_t;

  localparam logic [3:0] BURST_LAST = 4'(BURST_LEN);

  state_t      state_reg, state_next;
  logic [1:0]  gidx_reg, gidx_next;
  logic [1:0]  dst_reg, dst_next;
  logic [1:0]  last_reg, last_next;
  logic [3:0]  count_reg, count_next;
  logic        route_err_reg, route_err_next;

  logic [1:0]        sel [3];
  logic [DATA_W-1:0] src_data [3];
  logic [3:0]        full_ext;
  logic [2:0]        elig;
  logic [2:0]        bad_route;
  logic [1:0]        pick;
  logic              pick_valid;

  assign sel[0]      = dst_sel_fft;
  assign sel[1]      = dst_sel_fir;
  assign sel[2]      = dst_sel_iir;
  assign src_data[0] = fft_data_in;
  assign src_data[1] = fir_data_in;
  assign src_data[2] = iir_data_in;
  // Route 3 is reserved; treating it as permanently full keeps the index in range.
  assign full_ext    = {1'b1, dst_full};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_src
      assign bad_route[gi] = req[gi] && (sel[gi] == 2'd3 || sel[gi] == 2'(gi));
      assign elig[gi]      = req[gi] && !bad_route[gi] && !full_ext[sel[gi]];
    end
  endgenerate

  function automatic logic [1:0] rr_idx(input logic [1:0] last, input logic [1:0] step);
    logic [2:0] s;
    s = {1'b0, last} + {1'b0, step};
    return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
  endfunction

  // Scan farthest-first so the nearest eligible source after last wins.
  always_comb begin
    pick       = 2'd0;
    pick_valid = 1'b0;
    for (int k = 3; k >= 1; k--) begin
      if (elig[rr_idx(last_reg, 2'(k))]) begin
        pick       = rr_idx(last_reg, 2'(k));
        pick_valid = 1'b1;
      end
    end
  end

  always_comb begin
    state_next     = state_reg;
    gidx_next      = gidx_reg;
    dst_next       = dst_reg;
    last_next      = last_reg;
    count_next     = count_reg;
    src_pop        = 3'b000;
    dst_push       = 3'b000;
    grant          = 3'b000;
    data_bus       = '0;
    busy           = 1'b0;
    route_err_next = (state_reg == IDLE) && (|bad_route);
    case (state_reg)
      IDLE: begin
        if (enable && pick_valid) begin
          gidx_next  = pick;
          dst_next   = sel[pick];
          count_next = 4'd0;
          state_next = POP;
        end
      end
      POP: begin
        grant = 3'b001 << gidx_reg;
        busy  = 1'b1;
        if (req[gidx_reg] && !full_ext[dst_reg] && (count_reg == 4'd0 || enable)) begin
          src_pop    = 3'b001 << gidx_reg;
          state_next = XFER;
        end else begin
          last_next  = gidx_reg;
          state_next = IDLE;
        end
      end
      XFER: begin
        grant      = 3'b001 << gidx_reg;
        busy       = 1'b1;
        data_bus   = src_data[gidx_reg];
        dst_push   = 3'b001 << dst_reg;
        count_next = count_reg + 4'd1;
        if (count_reg + 4'd1 == BURST_LAST) begin
          last_next  = gidx_reg;
          state_next = IDLE;
        end else begin
          state_next = POP;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      gidx_reg      <= 2'd0;
      dst_reg       <= 2'd0;
      last_reg      <= 2'd2;
      count_reg     <= 4'd0;
      route_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      gidx_reg      <= gidx_next;
      dst_reg       <= dst_next;
      last_reg      <= last_next;
      count_reg     <= count_next;
      route_err_reg <= route_err_next;
    end
  end

  assign route_err = route_err_reg;

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Directed bench for data_bus_arbiter: reset, burst timing, round-robin order,
// full back-pressure, illegal routes and enable withdrawal.
module tb_data_bus_arbiter;

  localparam logic [31:0] FFT_W = 32'hA000_0001;
  localparam logic [31:0] FIR_W = 32'hB000_0002;
  localparam logic [31:0] IIR_W = 32'hC000_0003;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [2:0]  req;
  logic [1:0]  dst_sel_fft, dst_sel_fir, dst_sel_iir;
  logic [2:0]  dst_full;
  logic [31:0] fft_data_in, fir_data_in, iir_data_in;
  logic [2:0]  src_pop, dst_push, grant;
  logic [31:0] data_bus;
  logic        busy, route_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  data_bus_arbiter #(.DATA_W(32), .BURST_LEN(4)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .req(req),
    .dst_sel_fft(dst_sel_fft), .dst_sel_fir(dst_sel_fir), .dst_sel_iir(dst_sel_iir),
    .dst_full(dst_full), .fft_data_in(fft_data_in), .fir_data_in(fir_data_in),
    .iir_data_in(iir_data_in), .src_pop(src_pop), .dst_push(dst_push),
    .grant(grant), .data_bus(data_bus), .busy(busy), .route_err(route_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: sample just after the falling edge, i.e. mid-cycle after the rising edge.
  task automatic cyc(input string tag, input logic [2:0] e_pop, input logic [2:0] e_push,
                     input logic [2:0] e_grant, input logic e_busy, input logic [31:0] e_data);
    @(negedge clk);
    #1;
    check({tag, " src_pop"},  32'(src_pop),  32'(e_pop));
    check({tag, " dst_push"}, 32'(dst_push), 32'(e_push));
    check({tag, " grant"},    32'(grant),    32'(e_grant));
    check({tag, " busy"},     32'(busy),     32'(e_busy));
    check({tag, " data_bus"}, data_bus,      e_data);
    $display("[TB] %s pop=%b push=%b grant=%b busy=%b data=%h", tag, src_pop, dst_push, grant, busy, data_bus);
  endtask

  task automatic burst(input string tag, input logic [2:0] g, input logic [2:0] d,
                       input logic [31:0] w, input int n);
    for (int k = 0; k < n; k++) begin
      cyc({tag, " pop"},  g,      3'b000, g, 1'b1, 32'd0);
      cyc({tag, " xfer"}, 3'b000, d,      g, 1'b1, w);
    end
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    enable      = 1'b0;
    req         = 3'b000;
    dst_full    = 3'b000;
    dst_sel_fft = 2'd1;
    dst_sel_fir = 2'd2;
    dst_sel_iir = 2'd0;
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    fft_data_in = FFT_W;
    fir_data_in = FIR_W;
    iir_data_in = IIR_W;
    rst_n       = 1'b0;
    enable      = 1'b0;
    req         = 3'b000;
    dst_full    = 3'b000;
    dst_sel_fft = 2'd1;
    dst_sel_fir = 2'd2;
    dst_sel_iir = 2'd0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("reset grant", 32'(grant), 32'd0);
    check("reset src_pop", 32'(src_pop), 32'd0);
    check("reset dst_push", 32'(dst_push), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset route_err", 32'(route_err), 32'd0);
    check("reset data_bus", data_bus, 32'd0);
    rst_n = 1'b1;

    // 1: async reset mid-XFER, then fft wins over iir
    enable = 1'b1;
    req    = 3'b001;
    cyc("t1 pop",  3'b001, 3'b000, 3'b001, 1'b1, 32'd0);
    cyc("t1 xfer", 3'b000, 3'b010, 3'b001, 1'b1, FFT_W);
    rst_n = 1'b0;
    #1;
    check("t1 async grant", 32'(grant), 32'd0);
    check("t1 async dst_push", 32'(dst_push), 32'd0);
    check("t1 async data_bus", data_bus, 32'd0);
    check("t1 async busy", 32'(busy), 32'd0);
    req   = 3'b101;
    rst_n = 1'b1;
    cyc("t1 rr first", 3'b001, 3'b000, 3'b001, 1'b1, 32'd0);

    // 2: fft->fir, three words, then release on empty
    do_reset();
    enable = 1'b1;
    req    = 3'b001;
    cyc("t2 pop1",  3'b001, 3'b000, 3'b001, 1'b1, 32'd0);
    cyc("t2 push1", 3'b000, 3'b010, 3'b001, 1'b1, FFT_W);
    cyc("t2 pop2",  3'b001, 3'b000, 3'b001, 1'b1, 32'd0);
    cyc("t2 push2", 3'b000, 3'b010, 3'b001, 1'b1, FFT_W);
    cyc("t2 pop3",  3'b001, 3'b000, 3'b001, 1'b1, 32'd0);
    cyc("t2 push3", 3'b000, 3'b010, 3'b001, 1'b1, FFT_W);
    req = 3'b000;
    cyc("t2 release", 3'b000, 3'b000, 3'b001, 1'b1, 32'd0);
    cyc("t2 idle",    3'b000, 3'b000, 3'b000, 1'b0, 32'd0);

    // 3: all eligible -> fft, fir, iir, fft with full bursts
    do_reset();
    enable = 1'b1;
    req    = 3'b111;
    burst("t3 fft", 3'b001, 3'b010, FFT_W, 4);
    cyc("t3 idle a", 3'b000, 3'b000, 3'b000, 1'b0, 32'd0);
    burst("t3 fir", 3'b010, 3'b100, FIR_W, 4);
    cyc("t3 idle b", 3'b000, 3'b000, 3'b000, 1'b0, 32'd0);
    burst("t3 iir", 3'b100, 3'b001, IIR_W, 4);
    cyc("t3 idle c", 3'b000, 3'b000, 3'b000, 1'b0, 32'd0);
    cyc("t3 fft again", 3'b001, 3'b000, 3'b001, 1'b1, 32'd0);

    // 4: fir blocked by full iir input; served once full clears
    do_reset();
    enable   = 1'b1;
    req      = 3'b011;
    dst_full = 3'b100;
    burst("t4 fft", 3'b001, 3'b010, FFT_W, 4);
    dst_full = 3'b000;
    cyc("t4 idle",     3'b000, 3'b000, 3'b000, 1'b0, 32'd0);
    cyc("t4 fir pop",  3'b010, 3'b000, 3'b010, 1'b1, 32'd0);
    cyc("t4 fir xfer", 3'b000, 3'b100, 3'b010, 1'b1, FIR_W);

    // 5: illegal iir routes flag route_err and are never granted
    do_reset();
    enable      = 1'b1;
    req         = 3'b100;
    dst_sel_iir = 2'd2;
    cyc("t5 self route", 3'b000, 3'b000, 3'b000, 1'b0, 32'd0);
    check("t5 self route_err", 32'(route_err), 32'd1);
    dst_sel_iir = 2'd3;
    cyc("t5 rsvd route", 3'b000, 3'b000, 3'b000, 1'b0, 32'd0);
    check("t5 rsvd route_err", 32'(route_err), 32'd1);
    dst_sel_iir = 2'd0;
    cyc("t5 fixed pop", 3'b100, 3'b000, 3'b100, 1'b1, 32'd0);
    check("t5 fixed route_err", 32'(route_err), 32'd0);
    cyc("t5 fixed xfer", 3'b000, 3'b001, 3'b100, 1'b1, IIR_W);

    // 6: enable dropped before the second POP of an fft burst
    do_reset();
    enable = 1'b1;
    req    = 3'b011;
    cyc("t6 pop1",  3'b001, 3'b000, 3'b001, 1'b1, 32'd0);
    cyc("t6 push1", 3'b000, 3'b010, 3'b001, 1'b1, FFT_W);
    enable = 1'b0;
    cyc("t6 release", 3'b000, 3'b000, 3'b001, 1'b1, 32'd0);
    cyc("t6 idle1",   3'b000, 3'b000, 3'b000, 1'b0, 32'd0);
    cyc("t6 idle2",   3'b000, 3'b000, 3'b000, 1'b0, 32'd0);
    enable = 1'b1;
    cyc("t6 fir pop", 3'b010, 3'b000, 3'b010, 1'b1, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
